pe_dbuf_wr_agu: RTL
===================

// Module: pe_dbuf_wr_agu
// PURPOSE
//   Write-side address generator for a PE data buffer; the counterpart of
//   the read-side AGU. Accepts one beat per cycle from the buffer-fill
//   stream and emits the buffer write enable and write address.
//   The tile is row x col in one of three layouts. It signals done when
//   the tile is fully written, so the read AGU can be started.
// PARAMETERS
//   ADDR_W   8   buffer address width; all address arithmetic is mod 2^ADDR_W
//   IDX_W    4   width of row/col limits and counters
// PORTS
//   clk        in   1       clock
//   rst        in   1       synchronous reset, active high
//   start      in   1       latch config and begin a tile (honoured in IDLE only)
//   mode       in   2       0=row-major, 1=transposed, 2=fixed pitch, 3=as 0
//   base       in   ADDR_W  tile base address
//   row_lim    in   IDX_W   last row index (rows = row_lim+1)
//   col_lim    in   IDX_W   last col index (cols = col_lim+1)
//   in_valid   in   1       input beat present
//   in_ready   out  1       block accepts a beat; beat taken on in_valid&in_ready
//   wr_en      out  1       buffer write strobe (registered)
//   wr_addr    out  ADDR_W  buffer write address (registered)
//   busy       out  1       tile in progress
//   done       out  1       one-cycle pulse: last write of the tile issued
// BEHAVIOUR
//   Reset: state=IDLE; in_ready, wr_en, busy, done = 0; wr_addr = 0; counters = 0.
//   States:
//     IDLE --start--> RUN. Latch mode/base/row_lim/col_lim; clear row, col.
//     RUN --accept of beat (row_lim,col_lim)--> IDLE.
//   in_ready = busy = (state==RUN). A beat with start in IDLE is not accepted.
//   start while in RUN is ignored; latched config stays stable during RUN.
//   Counters:
//     col is the inner loop: 0..col_lim. It wraps to 0 and increments row.
//     row is the outer loop: 0..row_lim.
//     Counters advance only on an accepted beat; in_valid=0 stalls with no write.
//   Address of the accepted beat (r,c), computed mod 2^ADDR_W:
//     mode 0/3: base + r*(col_lim+1) + c
//     mode 1  : base + c*(row_lim+1) + r
//     mode 2  : base + r*16 + c        (fixed 16-word row pitch)
//   Use running stride accumulators; a multiplier is not required.
//   Latency: wr_en/wr_addr appear 1 cycle after the accepting edge.
//     wr_en is high for exactly one cycle per accepted beat.
//   done rises in the same cycle as the final wr_en. The FSM is back in IDLE
//     that cycle, so a new start is accepted in the same cycle as done.
//   Limits 0/0: a single beat at address base, then done.
//   Address overflow wraps silently; no error flag.
//   rst mid-tile: abort immediately to reset values; no done pulse.
// TESTING
//   1. Mode 0, base=0x10, row_lim=1, col_lim=2, in_valid held 1:
//      wr_addr 10,11,12,13,14,15 on consecutive cycles; done with 0x15.
//   2. Mode 1, same tile: wr_addr 10,12,14,11,13,15; done with 0x15.
//   3. Mode 2, base=0, row_lim=1, col_lim=1: wr_addr 00,01,10,11.
//   4. Mode 0, 2x2 tile, in_valid toggling 1,0,1,0...:
//      exactly 4 wr_en, no address skipped or repeated, busy high throughout.
//   5. Base=0xFE, mode 0, 1x4 tile: wr_addr FE,FF,00,01 (wrap).
//   6. rst after 3 beats, then start a new 1x1 tile:
//      no done for the aborted tile; new tile gives a single write at its base.
//      Also: start during RUN is ignored; start in the done cycle launches the
//      next tile.

Source files
------------

// File: rtl/pe_dbuf_wr_agu.sv
// Write-side address generator for a PE data buffer.
// Walks a row x col tile in row-major, transposed or fixed-pitch order
// and issues one registered buffer write per accepted fill-stream beat.
module pe_dbuf_wr_agu #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [IDX_W-1:0]  row_lim,
    input  logic [IDX_W-1:0]  col_lim,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PITCH = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  row_lim_q;
    logic [IDX_W-1:0]  col_lim_q;
    logic [IDX_W-1:0]  row_q;
    logic [IDX_W-1:0]  col_q;
    // Address of the first beat of the current outer-loop row.
    logic [ADDR_W-1:0] row_addr_q;
    // Address of the next beat to be accepted.
    logic [ADDR_W-1:0] cur_addr_q;
    // Per-mode strides: outer step and inner step.
    logic [ADDR_W-1:0] rstride_q;
    logic [ADDR_W-1:0] cstride_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              done_q;

    // Tile FSM, running address accumulators and registered write outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_lim_q  <= '0;
            col_lim_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_addr_q <= '0;
            cur_addr_q <= '0;
            rstride_q  <= '0;
            cstride_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        row_lim_q  <= row_lim;
                        col_lim_q  <= col_lim;
                        row_q      <= '0;
                        col_q      <= '0;
                        row_addr_q <= base;
                        cur_addr_q <= base;
                        case (mode)
                            2'd1: begin
                                rstride_q <= ADDR_W'(1);
                                cstride_q <= ADDR_W'(row_lim) + ADDR_W'(1);
                            end
                            2'd2: begin
                                rstride_q <= ADDR_W'(PITCH);
                                cstride_q <= ADDR_W'(1);
                            end
                            default: begin
                                rstride_q <= ADDR_W'(col_lim) + ADDR_W'(1);
                                cstride_q <= ADDR_W'(1);
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cur_addr_q;
                        if (col_q == col_lim_q) begin
                            col_q      <= '0;
                            row_q      <= row_q + IDX_W'(1);
                            row_addr_q <= row_addr_q + rstride_q;
                            cur_addr_q <= row_addr_q + rstride_q;
                            if (row_q == row_lim_q) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            col_q      <= col_q + IDX_W'(1);
                            cur_addr_q <= cur_addr_q + cstride_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign done     = done_q;

endmodule
